// File: rtl/frame_update_sched.sv
// -----------------------------------------------------------------------------
// frame_update_sched
//
// Per-frame update scheduler for the player character. At the start of each
// vertical blanking interval (optionally only every FRAME_DIV-th one) it
// latches the button levels, then runs the movement unit and the
// ground/collision unit one after the other through level req / done
// handshakes. The resulting position is committed to the draw path only if
// the whole sequence completes while still inside blanking, so the sprite
// never moves mid-frame. If blanking ends first, the update is dropped and
// the sticky overrun flag is raised.
//
// Optional feature (compile-time macro SCHED_TIMEOUT_EN):
//   defined     - each handshake stage may wait at most TIMEOUT_CYC cycles
//                 for its done; on expiry the update is dropped and the
//                 sticky timeout_err flag is raised.
//   not defined - stages wait until done or end of blanking; timeout_err
//                 is tied low.
//
// Parameters:
//   TIMEOUT_CYC  max cycles a stage waits for its done (>= 1)
//   FRAME_DIV    run an update every FRAME_DIV vblank starts (>= 1)
//   POS_X_RST    reset value of pos_x_draw
//   POS_Y_RST    reset value of pos_y_draw
//
// Ports:
//   clk                               system / pixel clock
//   rst                               synchronous active-high reset
//   vblnk                             vertical blanking flag
//   stepleft/stepright/stepjump       raw button levels
//   btn_left/btn_right/btn_jump       buttons latched for the current update
//   move_req / move_done              movement unit handshake
//   coll_req / coll_done              collision unit handshake
//   pos_x_in / pos_y_in               position from movement + collision
//   pos_x_draw / pos_y_draw           committed position for drawing
//   frame_cnt                         committed-update counter (wraps)
//   busy                              high while an update is in progress
//   overrun                           sticky: update aborted by end of blanking
//   timeout_err                       sticky: a stage exceeded TIMEOUT_CYC
// -----------------------------------------------------------------------------
module frame_update_sched #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned FRAME_DIV   = 1,
  parameter logic [11:0] POS_X_RST   = 12'd100,
  parameter logic [11:0] POS_Y_RST   = 12'd500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        stepleft,
  input  logic        stepright,
  input  logic        stepjump,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_jump,
  output logic        move_req,
  input  logic        move_done,
  output logic        coll_req,
  input  logic        coll_done,
  input  logic [11:0] pos_x_in,
  input  logic [11:0] pos_y_in,
  output logic [11:0] pos_x_draw,
  output logic [11:0] pos_y_draw,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    MOVE,
    COLL,
    COMMIT
  } state_t;

  // A zero divider or zero timeout has no meaningful behaviour.
  if (FRAME_DIV == 0 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("frame_update_sched: FRAME_DIV and TIMEOUT_CYC must be >= 1");
  end

  // Divider width stays at least one bit so FRAME_DIV = 1 still elaborates.
  localparam int unsigned      DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  state_t           state;
  logic             vblnk_d;
  logic [DIV_W-1:0] div_cnt;
  logic             frame_start;
  logic             launch;
  logic             stage_done;
  logic             stage_expired;
  logic             timeout_hit;

  assign frame_start = vblnk & ~vblnk_d;
  // The divider value is checked before it advances, so the first frame
  // start after reset always launches an update.
  assign launch      = frame_start & (div_cnt == '0);

  // Done of whichever handshake is currently active; a done from the other
  // unit is never looked at, so stray dones are harmless.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    stage_done = 1'b0;
    if (state == MOVE) begin
      stage_done = move_done;
    end else if (state == COLL) begin
      stage_done = coll_done;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  // Counter wide enough to hold TIMEOUT_CYC so it never wraps inside a stage.
  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] wait_cnt;

  // wait_cnt = number of cycles already spent in the current stage; it is
  // zero on the first cycle of MOVE and of COLL.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == LATCH || (state == MOVE && move_done)) begin
      wait_cnt <= '0;
    end else if (state == MOVE || state == COLL) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // True on the TIMEOUT_CYC-th cycle of a stage; a done in that very cycle
  // still counts as arriving in time.
  assign stage_expired = (wait_cnt == TO_LAST);
`else
  assign stage_expired = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  assign timeout_hit = stage_expired & ~stage_done;

  // Frame-start edge detector and update divider.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      vblnk_d <= 1'b0;
      div_cnt <= '0;
    end else begin
      vblnk_d <= vblnk;
      if (frame_start) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end
    end
  end

  // Sequencer. req, busy and the sticky flags are registered alongside the
  // state so they change exactly with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      btn_left   <= 1'b0;
      btn_right  <= 1'b0;
      btn_jump   <= 1'b0;
      move_req   <= 1'b0;
      coll_req   <= 1'b0;
      pos_x_draw <= POS_X_RST;
      pos_y_draw <= POS_Y_RST;
      frame_cnt  <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state <= LATCH;
            busy  <= 1'b1;
          end
        end

        LATCH: begin
          // Buttons are sampled here even if blanking has just ended, so
          // btn_* always reflect the most recent latch point.
          btn_left  <= stepleft;
          btn_right <= stepright;
          btn_jump  <= stepjump;
          if (!vblnk) begin
            state   <= IDLE;
            busy    <= 1'b0;
            overrun <= 1'b1;
          end else begin
            state    <= MOVE;
            move_req <= 1'b1;
          end
        end

        MOVE: begin
          // End of blanking wins over a simultaneous done: a late result
          // must not reach the draw path.
          if (!vblnk || timeout_hit) begin
            state    <= IDLE;
            busy     <= 1'b0;
            move_req <= 1'b0;
            if (!vblnk) overrun <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
            if (timeout_hit) timeout_err <= 1'b1;
`endif
          end else if (move_done) begin
            state    <= COLL;
            move_req <= 1'b0;
            coll_req <= 1'b1;
          end
        end

        COLL: begin
          if (!vblnk || timeout_hit) begin
            state    <= IDLE;
            busy     <= 1'b0;
            coll_req <= 1'b0;
            if (!vblnk) overrun <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
            if (timeout_hit) timeout_err <= 1'b1;
`endif
          end else if (coll_done) begin
            state    <= COMMIT;
            coll_req <= 1'b0;
          end
        end

        COMMIT: begin
          // Blanking is not checked here: both results are already in, so
          // the commit goes through even if vblnk falls this cycle.
          pos_x_draw <= pos_x_in;
          pos_y_draw <= pos_y_in;
          frame_cnt  <= frame_cnt + 16'd1;
          state      <= IDLE;
          busy       <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          move_req <= 1'b0;
          coll_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_update_sched.md
# frame_update_sched

Per-frame update scheduler for the player character. On each vertical-blanking start it latches the button inputs, then sequences the character movement unit and the ground/collision unit through req/done handshakes. It commits the resulting position to the draw path only if the whole sequence finished inside blanking, so the sprite never tears mid-frame. It sits between the keyboard/button front end, the movement and collision units, and the character draw stage.

## Interface
- TIMEOUT_CYC, 4096: max cycles a stage may wait for its done.
- FRAME_DIV, 1: run an update every FRAME_DIV vblank starts (≥1).
- POS_X_RST, 12'd100: reset value of pos_x_draw.
- POS_Y_RST, 12'd500: reset value of pos_y_draw.

Ports:
- clk  in  1  system/pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- vblnk  in  1  vertical blanking flag from the VGA timing chain.
- stepleft / stepright / stepjump  in  1 each  raw button levels.
- btn_left / btn_right / btn_jump  out  1 each  buttons latched for the current update.
- move_req  out  1  request to movement unit (level).
- move_done  in  1  movement unit finished.
- coll_req  out  1  request to collision/ground unit (level).
- coll_done  in  1  collision unit finished.
- pos_x_in / pos_y_in  in  12 each  position produced by movement+collision.
- pos_x_draw / pos_y_draw  out  12 each  committed position for drawing.
- frame_cnt  out  16  committed-update counter.
- busy  out  1  high whenever state ≠ IDLE.
- overrun  out  1  sticky: an update was aborted by end of blanking.
- timeout_err  out  1  sticky: a stage exceeded TIMEOUT_CYC.

## Operation
- Reset values: state IDLE, all btn_* 0, move_req/coll_req 0, pos_*_draw = POS_*_RST, frame_cnt 0, busy 0, overrun 0, timeout_err 0, divider 0, vblnk_d 0.
- Frame start = vblnk & ~vblnk_d, where vblnk_d is vblnk registered.
- The divider counts frame starts 0..FRAME_DIV-1 and then wraps. An update is launched only on a frame start seen while the divider = 0.
- FSM states and transitions:
  - IDLE → LATCH on a launched frame start.
  - LATCH: sample the step* inputs into btn_*; go to MOVE.
  - MOVE: hold move_req high; on move_done go to COLL.
  - COLL: hold coll_req high; on coll_done go to COMMIT.
  - COMMIT: pos_*_draw ← pos_*_in; frame_cnt += 1 (wraps at 16'hFFFF → 0); go to IDLE.
- Handshake rules:
  - Each req is a level held until the matching done is sampled high.
  - A done is ignored unless its own req is high.
  - A done asserted in the same cycle req first rises is accepted.
  - move_req and coll_req are never high together.
- Abort on end of blanking: if vblnk = 0 while in LATCH/MOVE/COLL → IDLE next cycle, req dropped, no commit, overrun ← 1. Subunits tolerate a req drop.
- COMMIT completes even if vblnk falls in that same cycle.
- btn_* hold their values until the next LATCH.
- Sticky flags clear only on rst.
- rst asserted mid-update: next cycle everything returns to reset values; no commit happens.

## Timing
- Frame start seen in cycle N (vblnk=1, vblnk_d=0) → state LATCH in N+1 → btn_* valid in N+2, with move_req high in N+2.
- move_done sampled high in cycle M → move_req low and coll_req high in M+1.
- coll_done sampled high in cycle C → COMMIT in C+1 → pos_*_draw and frame_cnt updated and visible in C+2, with busy low in C+2.
- Minimum update latency, done on first req cycle: frame start to new pos_*_draw = 5 cycles.
- Abort: vblnk=0 sampled in cycle A → busy and req low in A+1, overrun high in A+1.

## Configuration
- SCHED_TIMEOUT_EN defined:
  - A cycle counter is cleared on entry to MOVE and to COLL.
  - If done has not arrived after TIMEOUT_CYC cycles in the stage → IDLE, req dropped, no commit, timeout_err ← 1.
  - If the vblnk abort and the timeout fire in the same cycle, both flags are set.
- Not defined: no counter; stages wait indefinitely, limited only by the vblnk abort; timeout_err tied 0.

## Test plan
- Reset, then vblnk rise with move_done/coll_done returned 1 cycle after each req → pos_*_draw = pos_*_in 5..7 cycles later, frame_cnt = 1, overrun = 0.
- stepleft=1 held through LATCH, then dropped during MOVE → btn_left stays 1 until the next update's LATCH.
- coll_done withheld until vblnk falls → coll_req drops next cycle, overrun = 1, pos_*_draw unchanged, frame_cnt unchanged.
- FRAME_DIV=3, 6 vblank rises → exactly 2 updates (1st and 4th rises), frame_cnt = 2.
- SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, move_done never asserted, vblnk held high → abort after 16 cycles in MOVE, timeout_err = 1, no commit.
- rst pulsed during COLL → next cycle all outputs at reset values, including pos_*_draw = 100/500 and both sticky flags 0.
